int_hit_reduce: RTL

INT_HIT_REDUCE -- requirements
Module: int_hit_reduce

---
 rtl/int_hit_reduce_pkg.sv | 33 +++
 rtl/int_reduce_fifo.sv | 62 ++++++
 rtl/int_hit_reduce.sv | 130 +++++++++++++
 3 files changed

// File: rtl/int_hit_reduce_pkg.sv
// Shared ray-tracer types and constants.
// Holds the intersection-reduction bundles and their default sizes.
package int_hit_reduce_pkg;

  typedef logic [31:0] float_t;
  typedef logic [63:0] bari_uv_t;

  localparam int INT_REDUCE_NRAY       = 16;
  localparam int INT_REDUCE_FIFO_DEPTH = 4;

  typedef struct packed {
    logic        hit;
    float_t      t_int;
    bari_uv_t    uv;
    logic [15:0] triID;
    float_t      t_max;
    logic        last;
  } int_reduce_in_t;

  typedef struct packed {
    logic        hit;
    float_t      t_int;
    bari_uv_t    uv;
    logic [15:0] triID;
  } int_reduce_out_t;

  // Positive floats order the same as their magnitude bits.
  function automatic logic f_lt(input logic [30:0] a,
                                input logic [30:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/int_reduce_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Full/empty come from the count, so a same-cycle pop never frees a slot early.
module int_reduce_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push)
      wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)
      rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (do_push && !do_pop)
      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push)
        mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/int_hit_reduce.sv
// Per-ray closest-hit reduction; emits one result per leaf on in_last.
// Optional counters: define INT_REDUCE_STATS_EN to add stat_tests/stat_hits.
module int_hit_reduce
  import int_hit_reduce_pkg::*;
#(
  parameter int NRAY       = INT_REDUCE_NRAY,
  parameter int FIFO_DEPTH = INT_REDUCE_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(NRAY)-1:0] in_rayID,
  input  logic                    in_hit,
  input  logic [31:0]             in_t_int,
  input  logic [63:0]             in_uv,
  input  logic [15:0]             in_triID,
  input  logic [31:0]             in_t_max,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NRAY)-1:0] out_rayID,
  output logic                    out_hit,
  output logic [31:0]             out_t_int,
  output logic [63:0]             out_uv,
  output logic [15:0]             out_triID
`ifdef INT_REDUCE_STATS_EN
  ,
  output logic [31:0]             stat_tests,
  output logic [31:0]             stat_hits
`endif
);

  localparam int RID_W = $clog2(NRAY);
  localparam int OW    = RID_W + $bits(int_reduce_out_t);

  int_reduce_in_t  inp;
  int_reduce_out_t res_d;
  logic            acc, qual, push, pop;
  logic            full, empty;
  logic [OW-1:0]   head, out_w;
  logic            unused_sign;

  logic        found_q [NRAY];
  float_t      best_t_q [NRAY];
  bari_uv_t    best_uv_q [NRAY];
  logic [15:0] best_tri_q [NRAY];

  assign inp = {in_hit, in_t_int, in_uv, in_triID, in_t_max, in_last};
  assign unused_sign = inp.t_max[31];

  assign acc  = in_valid && in_ready;
  assign qual = acc && inp.hit
             && (inp.t_int[30:23] != 8'hFF)
             && f_lt(inp.t_int[30:0], inp.t_max[30:0])
             && (!found_q[in_rayID]
                 || f_lt(inp.t_int[30:0], best_t_q[in_rayID][30:0]));

  // Merge the same-cycle input so in_last reports the final best.
  always_comb begin
    res_d = '0;
    if (qual)
      res_d = {1'b1, inp.t_int, inp.uv, inp.triID};
    else if (found_q[in_rayID])
      res_d = {1'b1, best_t_q[in_rayID],
               best_uv_q[in_rayID], best_tri_q[in_rayID]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NRAY; i++) begin
        found_q[i]    <= 1'b0;
        best_t_q[i]   <= '0;
        best_uv_q[i]  <= '0;
        best_tri_q[i] <= '0;
      end
    end else if (acc) begin
      if (inp.last) begin
        found_q[in_rayID] <= 1'b0;
      end else if (qual) begin
        found_q[in_rayID]    <= 1'b1;
        best_t_q[in_rayID]   <= inp.t_int;
        best_uv_q[in_rayID]  <= inp.uv;
        best_tri_q[in_rayID] <= inp.triID;
      end
    end
  end

  assign push = acc && inp.last;
  assign pop  = out_valid && out_ready;

  int_reduce_fifo #(
    .W     (OW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({in_rayID, res_d}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_w     = out_valid ? head : '0;
  assign {out_rayID, out_hit, out_t_int, out_uv, out_triID} = out_w;

`ifdef INT_REDUCE_STATS_EN
  logic [31:0] tests_q, hits_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tests_q <= '0;
      hits_q  <= '0;
    end else begin
      if (acc && tests_q != '1)
        tests_q <= tests_q + 1'b1;
      if (qual && hits_q != '1)
        hits_q <= hits_q + 1'b1;
    end
  end

  assign stat_tests = tests_q;
  assign stat_hits  = hits_q;
`endif

endmodule
